kes_rr_scheduler: RTL and testbench

KES_RR_SCHEDULER -- requirements
Module: kes_rr_scheduler

---
 rtl/kes_rr_scheduler_if.sv | 42 ++++
 rtl/kes_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_kes_rr_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/kes_rr_scheduler_if.sv
// kes_rr_scheduler_if -- request/grant bundle between the syndrome buffers and
// the shared KES scheduler.
//   iRequestChannel [Channel]         per-channel request for the KES
//   iLastChunk      [Channel]         per-channel end-of-sequence flag
//   iKESAvail                         shared KES can accept a chunk this cycle
//   oKESAvail       [Channel]         one-hot push enable for the granted channel
//   oChannelNumber  [ChannelNumWidth] current / most recent granted channel
//   oGrantValid                       a grant is held
//   oTimeout                          watchdog forced a release (one-cycle pulse)
// master: requester side, slave: scheduler side.
interface kes_rr_scheduler_if #(
    parameter int unsigned Channel         = 4,
    parameter int unsigned ChannelNumWidth = 2
);
    logic [Channel-1:0]         iRequestChannel;
    logic [Channel-1:0]         iLastChunk;
    logic                       iKESAvail;
    logic [Channel-1:0]         oKESAvail;
    logic [ChannelNumWidth-1:0] oChannelNumber;
    logic                       oGrantValid;
    logic                       oTimeout;

    modport master (
        output iRequestChannel,
        output iLastChunk,
        output iKESAvail,
        input  oKESAvail,
        input  oChannelNumber,
        input  oGrantValid,
        input  oTimeout
    );

    modport slave (
        input  iRequestChannel,
        input  iLastChunk,
        input  iKESAvail,
        output oKESAvail,
        output oChannelNumber,
        output oGrantValid,
        output oTimeout
    );
endinterface

// File: rtl/kes_rr_scheduler.sv
// kes_rr_scheduler -- round-robin arbiter granting one syndrome buffer at a time
// access to the shared key-equation solver (KES).
// Ports:
//   iClock  rising-edge clock
//   iReset  synchronous, active-high reset
//   bus     kes_rr_scheduler_if.slave (requests, last-chunk flags, KES ready,
//           one-hot push enable, channel number, grant valid, timeout pulse)
// Optional feature: define KES_SCHED_WATCHDOG_EN to add a grant watchdog that
// forces a release after WatchdogCycles counted cycles and pulses oTimeout.
// oKESAvail is combinational (follows iKESAvail in the same cycle); all other
// outputs come straight from registers.
module kes_rr_scheduler #(
    parameter int unsigned Channel         = 4,
    parameter int unsigned ChannelNumWidth = 2,
    parameter int unsigned WatchdogCycles  = 1024
) (
    input  logic                 iClock,
    input  logic                 iReset,
    kes_rr_scheduler_if.slave    bus
);

    // Reject unsupported configurations at elaboration.
    if (Channel < 2 || Channel > 4 || (1 << ChannelNumWidth) < Channel
        || WatchdogCycles < 2) begin : gBadParams
        $error("kes_rr_scheduler: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                     rState;
    state_t                     nextState_c;
    logic [ChannelNumWidth-1:0] rGrant;
    logic [ChannelNumWidth-1:0] rLastServed;
    logic                       rGrantValid;

    logic                       grantTake_c;
    logic                       selFound_c;
    logic [ChannelNumWidth-1:0] selIndex_c;
    logic [ChannelNumWidth-1:0] probeIdx_c;
    logic                       lastGranted_c;
    logic                       reqGranted_c;
    logic                       wdExpire_c;

    assign lastGranted_c = bus.iLastChunk[rGrant];
    assign reqGranted_c  = bus.iRequestChannel[rGrant];

    // Round-robin pick: scan from farthest to nearest after rLastServed so the
    // nearest requester is the last (winning) assignment.
    always_comb begin
        selFound_c = 1'b0;
        selIndex_c = '0;
        probeIdx_c = '0;
        for (int i = int'(Channel); i >= 1; i--) begin
            probeIdx_c = ChannelNumWidth'((int'(rLastServed) + i) % int'(Channel));
            if (bus.iRequestChannel[probeIdx_c]) begin
                selFound_c = 1'b1;
                selIndex_c = probeIdx_c;
            end
        end
    end

    // Next-state decode; release reasons: last chunk, abort, watchdog.
    always_comb begin
        nextState_c = rState;
        grantTake_c = 1'b0;
        case (rState)
            S_IDLE: begin
                if (bus.iKESAvail && selFound_c) begin
                    nextState_c = S_GRANT;
                    grantTake_c = 1'b1;
                end
            end
            S_GRANT: begin
                if (lastGranted_c || !reqGranted_c || wdExpire_c) begin
                    nextState_c = S_RELEASE;
                end
            end
            S_RELEASE: nextState_c = S_IDLE;
            default:   nextState_c = S_IDLE;
        endcase
    end

    // State and grant bookkeeping.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rState      <= S_IDLE;
            rGrant      <= '0;
            rLastServed <= ChannelNumWidth'(Channel - 1);
            rGrantValid <= 1'b0;
        end else begin
            rState      <= nextState_c;
            rGrantValid <= (nextState_c == S_GRANT);
            if (grantTake_c) begin
                rGrant <= selIndex_c;
            end
            if (rState == S_RELEASE) begin
                rLastServed <= rGrant;
            end
        end
    end

`ifdef KES_SCHED_WATCHDOG_EN
    localparam int unsigned WdWidth = $clog2(WatchdogCycles) + 1;
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(WatchdogCycles - 1);

    logic [WdWidth-1:0] rWdCount;
    logic               rTimeout;
    logic               wdCount_c;

    // Only cycles where the KES could take data and the sequence is not ending count.
    assign wdCount_c  = (rState == S_GRANT) && bus.iKESAvail && !lastGranted_c;
    assign wdExpire_c = wdCount_c && reqGranted_c && (rWdCount == WdLimit);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            rWdCount <= '0;
            rTimeout <= 1'b0;
        end else begin
            rTimeout <= wdExpire_c;
            if (grantTake_c) begin
                rWdCount <= '0;
            end else if (wdCount_c) begin
                rWdCount <= rWdCount + WdWidth'(1);
            end
        end
    end

    assign bus.oTimeout = rTimeout;
`else
    assign wdExpire_c   = 1'b0;
    assign bus.oTimeout = 1'b0;
`endif

    assign bus.oKESAvail      = ((rState == S_GRANT) && bus.iKESAvail)
                                ? (Channel'(1) << rGrant) : '0;
    assign bus.oChannelNumber = rGrant;
    assign bus.oGrantValid    = rGrantValid;

endmodule

// File: tb/tb_kes_rr_scheduler.sv
// tb_kes_rr_scheduler -- directed self-checking bench for kes_rr_scheduler.
// Runs with a 4-channel instance and WatchdogCycles=16; the watchdog scenario
// follows whichever build (KES_SCHED_WATCHDOG_EN defined or not) is compiled.
module tb_kes_rr_scheduler;

    localparam int unsigned Channel         = 4;
    localparam int unsigned ChannelNumWidth = 2;
    localparam int unsigned WatchdogCycles  = 16;

    logic iClock;
    logic iReset;

    int assertCount;
    int failCount;

    kes_rr_scheduler_if #(
        .Channel         (Channel),
        .ChannelNumWidth (ChannelNumWidth)
    ) bus ();

    kes_rr_scheduler #(
        .Channel         (Channel),
        .ChannelNumWidth (ChannelNumWidth),
        .WatchdogCycles  (WatchdogCycles)
    ) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic checkEqual(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    initial begin
        logic [3:0] oneHot;
        assertCount = 0;
        failCount   = 0;

        iReset              = 1'b1;
        bus.iRequestChannel = '0;
        bus.iLastChunk      = '0;
        bus.iKESAvail       = 1'b0;
        tick();
        tick();
        iReset = 1'b0;
        checkEqual("reset_grant_valid", 32'(bus.oGrantValid), 32'd0);
        checkEqual("reset_kes_avail", 32'(bus.oKESAvail), 32'd0);
        checkEqual("reset_channel", 32'(bus.oChannelNumber), 32'd0);
        checkEqual("reset_timeout", 32'(bus.oTimeout), 32'd0);

        // No grant while the KES is busy, whatever the requests.
        bus.iRequestChannel = 4'b1111;
        tick();
        tick();
        checkEqual("no_grant_kes_busy", 32'(bus.oGrantValid), 32'd0);

        // All channels requesting: order 0,1,2,3,0, each ended by last chunk.
        bus.iKESAvail = 1'b1;
        for (int k = 0; k < 5; k++) begin
            oneHot = 4'b0001 << (k % 4);
            tick();
            checkEqual("rr_grant_valid", 32'(bus.oGrantValid), 32'd1);
            checkEqual("rr_channel", 32'(bus.oChannelNumber), 32'(k % 4));
            checkEqual("rr_kes_avail", 32'(bus.oKESAvail), 32'(oneHot));
            bus.iLastChunk = oneHot;
            tick();
            checkEqual("rr_release_valid", 32'(bus.oGrantValid), 32'd0);
            checkEqual("rr_release_kes", 32'(bus.oKESAvail), 32'd0);
            checkEqual("rr_release_channel_hold", 32'(bus.oChannelNumber), 32'(k % 4));
            bus.iLastChunk = '0;
            tick();
            checkEqual("rr_idle_valid", 32'(bus.oGrantValid), 32'd0);
            checkEqual("rr_idle_channel_hold", 32'(bus.oChannelNumber), 32'(k % 4));
        end

        // Grant ch2, KES stalls for 5 cycles: grant held, push enable dropped.
        bus.iRequestChannel = 4'b0100;
        tick();
        checkEqual("stall_grant_channel", 32'(bus.oChannelNumber), 32'd2);
        bus.iKESAvail = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkEqual("stall_kes_avail", 32'(bus.oKESAvail), 32'd0);
            tick();
            checkEqual("stall_grant_valid", 32'(bus.oGrantValid), 32'd1);
            checkEqual("stall_channel", 32'(bus.oChannelNumber), 32'd2);
        end
        bus.iKESAvail = 1'b1;
        #1;
        checkEqual("stall_resume_kes", 32'(bus.oKESAvail), 32'b0100);
        bus.iLastChunk = 4'b0100;
        tick();
        bus.iLastChunk = '0;
        tick();

        // Grant ch1; last-chunk flags of other channels are ignored.
        bus.iRequestChannel = 4'b0010;
        tick();
        checkEqual("ignore_grant_channel", 32'(bus.oChannelNumber), 32'd1);
        bus.iLastChunk = 4'b1001;
        tick();
        checkEqual("ignore_other_last", 32'(bus.oGrantValid), 32'd1);
        tick();
        checkEqual("ignore_other_last2", 32'(bus.oGrantValid), 32'd1);
        bus.iLastChunk = 4'b0010;
        tick();
        checkEqual("own_last_release", 32'(bus.oGrantValid), 32'd0);
        bus.iLastChunk = '0;
        tick();
        checkEqual("own_last_idle", 32'(bus.oGrantValid), 32'd0);
        tick();
        checkEqual("regrant_two_later", 32'(bus.oGrantValid), 32'd1);
        checkEqual("regrant_channel", 32'(bus.oChannelNumber), 32'd1);
        bus.iLastChunk = 4'b0010;
        tick();
        bus.iLastChunk = '0;
        tick();

        // Grant ch3 (after ch1 with ch0 and ch3 requesting), then abort it.
        bus.iRequestChannel = 4'b1001;
        tick();
        checkEqual("abort_grant_channel", 32'(bus.oChannelNumber), 32'd3);
        bus.iRequestChannel = 4'b0001;
        tick();
        checkEqual("abort_release", 32'(bus.oGrantValid), 32'd0);
        tick();
        tick();
        checkEqual("abort_next_valid", 32'(bus.oGrantValid), 32'd1);
        checkEqual("abort_next_channel", 32'(bus.oChannelNumber), 32'd0);
        bus.iLastChunk = 4'b0001;
        tick();
        bus.iLastChunk = '0;
        tick();

        // Long grant on ch0 with no last chunk.
        bus.iRequestChannel = 4'b0011;
        bus.iRequestChannel = 4'b0001;
        tick();
        checkEqual("wd_grant_channel", 32'(bus.oChannelNumber), 32'd0);
        bus.iRequestChannel = 4'b0011;
        for (int k = 1; k < 16; k++) begin
            tick();
        end
        checkEqual("wd_cycle16_valid", 32'(bus.oGrantValid), 32'd1);
        checkEqual("wd_cycle16_no_timeout", 32'(bus.oTimeout), 32'd0);
`ifdef KES_SCHED_WATCHDOG_EN
        tick();
        checkEqual("wd_release_valid", 32'(bus.oGrantValid), 32'd0);
        checkEqual("wd_timeout_pulse", 32'(bus.oTimeout), 32'd1);
        tick();
        checkEqual("wd_timeout_single", 32'(bus.oTimeout), 32'd0);
        tick();
        checkEqual("wd_next_channel", 32'(bus.oChannelNumber), 32'd1);
        checkEqual("wd_next_valid", 32'(bus.oGrantValid), 32'd1);
        // Last chunk on the expiring cycle wins: normal release, no pulse.
        for (int k = 1; k < 16; k++) begin
            tick();
        end
        bus.iLastChunk = 4'b0010;
        tick();
        checkEqual("wd_tie_release", 32'(bus.oGrantValid), 32'd0);
        checkEqual("wd_tie_no_timeout", 32'(bus.oTimeout), 32'd0);
        bus.iLastChunk = '0;
        tick();
`else
        for (int k = 0; k < 8; k++) begin
            tick();
            checkEqual("nowd_held", 32'(bus.oGrantValid), 32'd1);
            checkEqual("nowd_timeout", 32'(bus.oTimeout), 32'd0);
        end
        bus.iLastChunk = 4'b0001;
        tick();
        bus.iLastChunk = '0;
        tick();
        tick();
        checkEqual("nowd_next_channel", 32'(bus.oChannelNumber), 32'd1);
        bus.iLastChunk = 4'b0010;
        tick();
        bus.iLastChunk = '0;
        tick();
`endif

        // Reset in the middle of a grant on ch2.
        bus.iRequestChannel = 4'b0100;
        tick();
        checkEqual("rst_pre_channel", 32'(bus.oChannelNumber), 32'd2);
        iReset = 1'b1;
        tick();
        checkEqual("rst_mid_valid", 32'(bus.oGrantValid), 32'd0);
        checkEqual("rst_mid_kes", 32'(bus.oKESAvail), 32'd0);
        checkEqual("rst_mid_channel", 32'(bus.oChannelNumber), 32'd0);
        checkEqual("rst_mid_timeout", 32'(bus.oTimeout), 32'd0);
        iReset = 1'b0;
        bus.iRequestChannel = 4'b1111;
        tick();
        checkEqual("rst_first_valid", 32'(bus.oGrantValid), 32'd1);
        checkEqual("rst_first_channel", 32'(bus.oChannelNumber), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
